// File: rtl/fpmul_issue_ctrl.sv
// Two-requester issue controller for a fixed-latency FP multiplier.
// Round-robin arbitration, credit-limited issue and an in-order result FIFO.
module fpmul_issue_ctrl #(
  parameter int LAT    = 4,
  parameter int ODEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        REQ0_VALID,
  input  logic [31:0] REQ0_A,
  input  logic [31:0] REQ0_B,
  output logic        REQ0_READY,
  input  logic        REQ1_VALID,
  input  logic [31:0] REQ1_A,
  input  logic [31:0] REQ1_B,
  output logic        REQ1_READY,
  output logic [31:0] MUL_A,
  output logic [31:0] MUL_B,
  input  logic [31:0] MUL_Z,
  output logic        RES_VALID,
  output logic [31:0] RES_DATA,
  output logic        RES_ID,
  input  logic        RES_READY,
  output logic        BUSY
);
  localparam int AW = $clog2(ODEPTH);
  localparam int CW = AW + 1;

  logic [LAT-1:0] vld_pipe;
  logic [LAT-1:0] id_pipe;
  logic [CW-1:0]  occ;
  logic [CW-1:0]  count;
  logic [AW-1:0]  wptr, rptr;
  logic           ptr;
  logic [31:0]    data_mem [ODEPTH];
  logic           id_mem   [ODEPTH];

  logic grant0, grant1, allowed, accept, wr, pop;

  // RST_n gates READY so nothing is offered while reset is held,
  // including the very first edges before state is known.
  always_comb begin
    grant0     = REQ0_VALID && (!REQ1_VALID || !ptr);
    grant1     = REQ1_VALID && (!REQ0_VALID ||  ptr);
    allowed    = RST_n && (occ < CW'(ODEPTH));
    REQ0_READY = grant0 && allowed;
    REQ1_READY = grant1 && allowed;
    accept     = REQ0_READY || REQ1_READY;
    wr         = vld_pipe[LAT-1];
    RES_VALID  = (count != '0);
    pop        = RES_VALID && RES_READY;
    RES_DATA   = data_mem[rptr];
    RES_ID     = id_mem[rptr];
    BUSY       = (|vld_pipe) || (count != '0);
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
      occ      <= '0;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      ptr      <= 1'b0;
      MUL_A    <= '0;
      MUL_B    <= '0;
    end else begin
      vld_pipe[0] <= accept;
      id_pipe[0]  <= REQ1_READY;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
      if (accept) begin
        MUL_A <= REQ1_READY ? REQ1_A : REQ0_A;
        MUL_B <= REQ1_READY ? REQ1_B : REQ0_B;
        ptr   <= !REQ1_READY;
      end
      // Credit is released only after the pop edge, never same-cycle.
      occ   <= occ + CW'(accept) - CW'(pop);
      count <= count + CW'(wr) - CW'(pop);
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_n && wr) begin
      data_mem[wptr] <= MUL_Z;
      id_mem[wptr]   <= id_pipe[LAT-1];
    end
  end
endmodule
